tone_gen: RTL and testbench
===========================

Name: tone_gen

Overview:
- Programmable square-wave tone generator: the output-side counterpart of the mic frequency counter.
- Accepts a target pitch in Hz (same 16-bit Hz format the counter reports) and an optional duration in ms.
- Computes the half-period with an internal sequential divider, then drives a 50%-duty square wave to the speaker/PWM path.
- Used to play reference notes the singer's measured pitch is compared against.

Parameters:
SYS_FREQ, 100000000, clk frequency in Hz; must be ≤ 2^32-1 and divisible by 1000
MIN_FREQ, 20, lowest accepted tone frequency in Hz
MAX_FREQ, 20000, highest accepted tone frequency in Hz

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle request; captures freq_in and dur_ms
stop  input  1  abort current tone
freq_in  input  16  requested tone frequency, Hz
dur_ms  input  16  tone duration in ms; 0 = play until stop or retrigger
tone_out  output  1  square-wave output
busy  output  1  high in DIVIDE or PLAY
done  output  1  one-cycle pulse when a timed tone expires naturally
err  output  1  one-cycle pulse when start carries freq_in outside [MIN_FREQ, MAX_FREQ]
cur_freq  output  16  frequency currently playing; 0 when not in PLAY

Behaviour:
- Reset: clk is clock; reset is asynchronous, active-high. Reset forces state IDLE and all outputs to 0 (tone_out, busy, done, err, cur_freq), and clears every internal counter. Reset mid-tone aborts immediately with no done pulse.
- FSM states and transitions:
  - IDLE: start with valid freq -> DIVIDE; start with invalid freq -> err=1 for one cycle, remain IDLE.
  - DIVIDE: runs a restoring divider of SYS_FREQ (32-bit) by 2*freq (17-bit). Exactly 32 cycles, then enters PLAY on the following edge with half_period = floor(SYS_FREQ/(2*freq)).
  - PLAY:
    - On entry, tone_out=0, half_cnt=0, ms_cnt=0, ms_left=dur_ms, and cur_freq=captured freq.
    - Each cycle half_cnt increments. When half_cnt == half_period-1, half_cnt <= 0 and tone_out toggles. The first rising edge therefore occurs half_period cycles after PLAY entry.
- Duration (dur_ms ≠ 0):
  - ms_cnt wraps at SYS_FREQ/1000-1; each wrap decrements ms_left.
  - When ms_left reaches 0: go to IDLE, force tone_out=0 and cur_freq=0, and pulse done for one cycle.
  - dur_ms=0: no expiry.
- start in PLAY or DIVIDE is a retrigger:
  - Valid freq: capture new inputs, force tone_out=0, restart DIVIDE. No done pulse.
  - Invalid freq: err pulse, current activity continues unchanged.
- stop in DIVIDE or PLAY: go to IDLE with tone_out=0 and cur_freq=0 on the next edge, no done pulse. stop in IDLE is ignored.
- Priority on the same cycle: stop > start > duration expiry. Expiry coinciding with a valid start yields a retrigger and no done pulse.
- busy is registered: it rises the cycle after start is accepted and falls the cycle after returning to IDLE.
- Arithmetic: divider and half_cnt are 32 bits; ms_left is 16 bits; ms_cnt is $clog2(SYS_FREQ/1000) bits. No wrap-around is possible within the valid range.

Test Plan:
- SYS_FREQ=1000000, freq_in=1000, dur_ms=3, start pulse:
  - busy rises next cycle.
  - PLAY starts 33 cycles after start.
  - tone_out toggles every 500 cycles, giving 3 full periods.
  - done pulses once at PLAY+3000 cycles.
  - tone_out=0, cur_freq=0, busy=0 afterwards.
- freq_in=19 and freq_in=20001 start -> err pulse one cycle, busy stays 0, tone_out stays 0; freq_in=20 and 20000 accepted (half_period 25000 and 25).
- dur_ms=0, freq_in=440 (SYS_FREQ=1000000):
  - half_period=1136; tone runs indefinitely.
  - stop at an arbitrary cycle -> tone_out=0 and busy=0 next edge, no done.
- During PLAY at 1000 Hz, start with freq_in=2000 -> tone_out forced 0, 32-cycle DIVIDE, then half_period=250, cur_freq=2000, no done pulse.
- Same-cycle events:
  - start and stop together -> IDLE, no err/done.
  - Expiry cycle with valid start -> retrigger, no done.
- Reset asserted mid-PLAY with tone_out=1 -> all outputs 0 immediately (async). After release, state is IDLE and a new start works normally.

Source files
------------

// File: rtl/tone_gen.sv
// tone_gen: programmable 50%-duty square-wave tone generator.
// A start request captures a pitch (Hz) and an optional duration (ms).
// The half-period in clock cycles is computed by a 32-step restoring
// divider, and then a timed or free-running square wave is played.
module tone_gen #(
  parameter int unsigned SYS_FREQ = 100000000,
  parameter int unsigned MIN_FREQ = 20,
  parameter int unsigned MAX_FREQ = 20000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] freq_in,
  input  logic [15:0] dur_ms,
  output logic        tone_out,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] cur_freq
);

  localparam int unsigned MS_TICKS = SYS_FREQ / 1000;
  localparam int unsigned MS_W     = (MS_TICKS > 1) ? $clog2(MS_TICKS) : 1;
  localparam logic [MS_W-1:0] MS_LAST  = MS_W'(MS_TICKS - 1);
  localparam logic [31:0]     DIVIDEND = 32'(SYS_FREQ);
  localparam logic [15:0]     MIN_F    = 16'(MIN_FREQ);
  localparam logic [15:0]     MAX_F    = 16'(MAX_FREQ);
  localparam logic [5:0]      DIV_STEPS = 6'd32;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIVIDE = 2'd1,
    S_PLAY   = 2'd2
  } state_t;

  state_t          state_q, state_d;

  // Captured request
  logic [15:0]     freq_q, freq_d;
  logic [15:0]     dur_q, dur_d;

  // Restoring divider: quo_q starts as the dividend and is shifted out
  // MSB-first while quotient bits are shifted in at the LSB.
  logic [31:0]     quo_q, quo_d;
  logic [16:0]     rem_q, rem_d;
  logic [5:0]      dcnt_q, dcnt_d;

  // Playback counters
  logic [31:0]     half_period_q, half_period_d;
  logic [31:0]     half_cnt_q, half_cnt_d;
  logic [MS_W-1:0] ms_cnt_q, ms_cnt_d;
  logic [15:0]     ms_left_q, ms_left_d;

  // Registered outputs
  logic            tone_q, tone_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [15:0]     cur_freq_q, cur_freq_d;

  // Divider datapath helpers
  logic [16:0]     divisor;
  logic [17:0]     rem_sh;
  logic [17:0]     rem_diff;
  logic            freq_valid;

  assign divisor    = {freq_q, 1'b0};
  assign rem_sh     = {rem_q, quo_q[31]};
  assign rem_diff   = rem_sh - {1'b0, divisor};
  assign freq_valid = (freq_in >= MIN_F) && (freq_in <= MAX_F);

  // Next-state and datapath: stop beats start, start beats expiry.
  always_comb begin
    state_d       = state_q;
    freq_d        = freq_q;
    dur_d         = dur_q;
    quo_d         = quo_q;
    rem_d         = rem_q;
    dcnt_d        = dcnt_q;
    half_period_d = half_period_q;
    half_cnt_d    = half_cnt_q;
    ms_cnt_d      = ms_cnt_q;
    ms_left_d     = ms_left_q;
    tone_d        = tone_q;
    cur_freq_d    = cur_freq_q;
    done_d        = 1'b0;
    err_d         = 1'b0;

    if (state_q == S_IDLE) begin
      // stop is meaningless while idle, so only start is considered
      if (start) begin
        if (freq_valid) begin
          state_d    = S_DIVIDE;
          freq_d     = freq_in;
          dur_d      = dur_ms;
          quo_d      = DIVIDEND;
          rem_d      = '0;
          dcnt_d     = '0;
          tone_d     = 1'b0;
          cur_freq_d = '0;
        end else begin
          err_d = 1'b1;
        end
      end
    end else if (stop) begin
      state_d    = S_IDLE;
      tone_d     = 1'b0;
      cur_freq_d = '0;
    end else if (start && freq_valid) begin
      // Retrigger: restart the divide with the new request
      state_d    = S_DIVIDE;
      freq_d     = freq_in;
      dur_d      = dur_ms;
      quo_d      = DIVIDEND;
      rem_d      = '0;
      dcnt_d     = '0;
      tone_d     = 1'b0;
      cur_freq_d = '0;
    end else begin
      // An invalid start only flags an error; activity carries on below
      err_d = start;
      case (state_q)
        S_DIVIDE: begin
          if (dcnt_q == DIV_STEPS) begin
            state_d       = S_PLAY;
            half_period_d = quo_q;
            half_cnt_d    = '0;
            ms_cnt_d      = '0;
            ms_left_d     = dur_q;
            tone_d        = 1'b0;
            cur_freq_d    = freq_q;
          end else begin
            dcnt_d = dcnt_q + 6'd1;
            if (rem_sh >= {1'b0, divisor}) begin
              rem_d = rem_diff[16:0];
              quo_d = {quo_q[30:0], 1'b1};
            end else begin
              rem_d = rem_sh[16:0];
              quo_d = {quo_q[30:0], 1'b0};
            end
          end
        end
        S_PLAY: begin
          if (half_cnt_q == half_period_q - 32'd1) begin
            half_cnt_d = '0;
            tone_d     = ~tone_q;
          end else begin
            half_cnt_d = half_cnt_q + 32'd1;
          end
          // ms_left of 0 means untimed, so it is never decremented
          if (ms_cnt_q == MS_LAST) begin
            ms_cnt_d = '0;
            if (ms_left_q != '0) begin
              ms_left_d = ms_left_q - 16'd1;
              if (ms_left_q == 16'd1) begin
                state_d    = S_IDLE;
                tone_d     = 1'b0;
                cur_freq_d = '0;
                done_d     = 1'b1;
              end
            end
          end else begin
            ms_cnt_d = ms_cnt_q + MS_W'(1);
          end
        end
        default: begin
          state_d    = S_IDLE;
          tone_d     = 1'b0;
          cur_freq_d = '0;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      freq_q        <= '0;
      dur_q         <= '0;
      quo_q         <= '0;
      rem_q         <= '0;
      dcnt_q        <= '0;
      half_period_q <= '0;
      half_cnt_q    <= '0;
      ms_cnt_q      <= '0;
      ms_left_q     <= '0;
      tone_q        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      cur_freq_q    <= '0;
    end else begin
      state_q       <= state_d;
      freq_q        <= freq_d;
      dur_q         <= dur_d;
      quo_q         <= quo_d;
      rem_q         <= rem_d;
      dcnt_q        <= dcnt_d;
      half_period_q <= half_period_d;
      half_cnt_q    <= half_cnt_d;
      ms_cnt_q      <= ms_cnt_d;
      ms_left_q     <= ms_left_d;
      tone_q        <= tone_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
      cur_freq_q    <= cur_freq_d;
    end
  end

  assign tone_out = tone_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign cur_freq = cur_freq_q;

endmodule

// File: tb/tb_tone_gen.sv
// tb_tone_gen: directed self-checking bench for tone_gen at SYS_FREQ = 1 MHz.
module tb_tone_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        stop;
  logic [15:0] freq_in;
  logic [15:0] dur_ms;
  logic        tone_out;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] cur_freq;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  tone_gen #(
    .SYS_FREQ(1000000),
    .MIN_FREQ(20),
    .MAX_FREQ(20000)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .freq_in  (freq_in),
    .dur_ms   (dur_ms),
    .tone_out (tone_out),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .cur_freq (cur_freq)
  );

  always #5 clk = ~clk;

  // Count every done pulse, independently of the directed checks
  always @(negedge clk) if (done === 1'b1) done_seen++;

  typedef struct {
    logic [15:0] freq;
    logic        exp_err;
    int          hp;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic start_tone(input logic [15:0] f, input logic [15:0] d);
    freq_in = f;
    dur_ms  = d;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  // From just after the accepting edge to just after PLAY entry (33 edges)
  task automatic to_play(input logic [15:0] f);
    repeat (32) tick();
    check("divide_cur_freq", cur_freq, 0);
    tick();
    check("play_cur_freq", cur_freq, f);
    check("play_entry_tone", tone_out, 0);
  endtask

  task automatic wait_tone(input logic lvl, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (tone_out !== lvl && n < 40000);
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  initial begin
    vec_t vec[10];
    int   n;
    int   d0;
    int   rises;
    int   dones;
    int   done_at;
    logic prev;

    vec[0] = '{freq: 16'd19,    exp_err: 1'b1, hp: 0};
    vec[1] = '{freq: 16'd20001, exp_err: 1'b1, hp: 0};
    vec[2] = '{freq: 16'd0,     exp_err: 1'b1, hp: 0};
    vec[3] = '{freq: 16'd65535, exp_err: 1'b1, hp: 0};
    vec[4] = '{freq: 16'd20,    exp_err: 1'b0, hp: 25000};
    vec[5] = '{freq: 16'd20000, exp_err: 1'b0, hp: 25};
    vec[6] = '{freq: 16'd19999, exp_err: 1'b0, hp: 25};
    vec[7] = '{freq: 16'd440,   exp_err: 1'b0, hp: 1136};
    vec[8] = '{freq: 16'd1000,  exp_err: 1'b0, hp: 500};
    vec[9] = '{freq: 16'd12345, exp_err: 1'b0, hp: 40};

    reset   = 1'b1;
    start   = 1'b0;
    stop    = 1'b0;
    freq_in = '0;
    dur_ms  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tone", tone_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_cur_freq", cur_freq, 0);
    reset = 1'b0;
    tick();

    // Stop while idle has no effect
    do_stop();
    check("idle_stop_busy", busy, 0);

    // Frequency acceptance and measured half-period, table driven
    for (int i = 0; i < 10; i++) begin
      start_tone(vec[i].freq, 16'd0);
      check($sformatf("v%0d_err", i), err, vec[i].exp_err);
      check($sformatf("v%0d_busy", i), busy, !vec[i].exp_err);
      if (vec[i].exp_err) begin
        tick();
        check($sformatf("v%0d_err_pulse", i), err, 0);
        check($sformatf("v%0d_idle_busy", i), busy, 0);
        check($sformatf("v%0d_idle_tone", i), tone_out, 0);
      end else begin
        to_play(vec[i].freq);
        wait_tone(1'b1, n);
        check($sformatf("v%0d_rise", i), n, vec[i].hp);
        wait_tone(1'b0, n);
        check($sformatf("v%0d_fall", i), n, vec[i].hp);
        d0 = done_seen;
        do_stop();
        check($sformatf("v%0d_stop_tone", i), tone_out, 0);
        check($sformatf("v%0d_stop_busy", i), busy, 0);
        check($sformatf("v%0d_stop_cur", i), cur_freq, 0);
        tick();
        check($sformatf("v%0d_stop_nodone", i), done_seen, d0);
      end
    end

    // Timed tone: 1000 Hz for 3 ms
    start_tone(16'd1000, 16'd3);
    check("timed_busy_rise", busy, 1);
    to_play(16'd1000);
    rises   = 0;
    dones   = 0;
    done_at = 0;
    prev    = 1'b0;
    for (int k = 1; k <= 3000; k++) begin
      tick();
      if (tone_out && !prev) rises++;
      prev = tone_out;
      if (done) begin
        dones++;
        done_at = k;
      end
    end
    check("timed_rises", rises, 3);
    check("timed_done_count", dones, 1);
    check("timed_done_at", done_at, 3000);
    check("timed_end_tone", tone_out, 0);
    check("timed_end_cur", cur_freq, 0);
    check("timed_end_busy", busy, 0);
    tick();
    check("timed_done_pulse", done, 0);

    // Retrigger during PLAY at a new frequency
    start_tone(16'd1000, 16'd0);
    to_play(16'd1000);
    repeat (600) tick();
    check("retrig_tone_high", tone_out, 1);
    d0 = done_seen;
    start_tone(16'd2000, 16'd0);
    check("retrig_tone_forced", tone_out, 0);
    check("retrig_cur_zero", cur_freq, 0);
    check("retrig_busy", busy, 1);
    to_play(16'd2000);
    wait_tone(1'b1, n);
    check("retrig_hp", n, 250);
    check("retrig_nodone", done_seen, d0);
    do_stop();

    // Invalid start while playing: error pulse, tone undisturbed
    start_tone(16'd1000, 16'd0);
    to_play(16'd1000);
    repeat (100) tick();
    start_tone(16'd5, 16'd0);
    check("bad_retrig_err", err, 1);
    check("bad_retrig_cur", cur_freq, 1000);
    check("bad_retrig_busy", busy, 1);
    tick();
    check("bad_retrig_err_pulse", err, 0);
    wait_tone(1'b1, n);
    check("bad_retrig_rise", n, 398);
    do_stop();

    // Start and stop on the same cycle: stop wins
    start_tone(16'd440, 16'd0);
    to_play(16'd440);
    repeat (50) tick();
    d0      = done_seen;
    freq_in = 16'd1000;
    start   = 1'b1;
    stop    = 1'b1;
    tick();
    start   = 1'b0;
    stop    = 1'b0;
    check("ss_busy", busy, 0);
    check("ss_err", err, 0);
    check("ss_tone", tone_out, 0);
    check("ss_cur", cur_freq, 0);
    tick();
    check("ss_stays_idle", busy, 0);
    check("ss_nodone", done_seen, d0);

    // Stop during DIVIDE
    start_tone(16'd440, 16'd0);
    repeat (5) tick();
    do_stop();
    check("divstop_busy", busy, 0);
    repeat (40) tick();
    check("divstop_cur", cur_freq, 0);
    check("divstop_idle", busy, 0);

    // Expiry coinciding with a valid start: retrigger, no done
    start_tone(16'd1000, 16'd1);
    to_play(16'd1000);
    repeat (999) tick();
    check("exp_pre_busy", busy, 1);
    d0 = done_seen;
    start_tone(16'd2000, 16'd0);
    check("exp_retrig_busy", busy, 1);
    check("exp_retrig_tone", tone_out, 0);
    to_play(16'd2000);
    check("exp_retrig_nodone", done_seen, d0);
    wait_tone(1'b1, n);
    check("exp_retrig_hp", n, 250);
    do_stop();

    // Asynchronous reset mid-tone while tone_out is high
    start_tone(16'd1000, 16'd0);
    to_play(16'd1000);
    repeat (700) tick();
    check("rmid_tone_high", tone_out, 1);
    d0 = done_seen;
    #3 reset = 1'b1;
    #1;
    check("rmid_tone", tone_out, 0);
    check("rmid_busy", busy, 0);
    check("rmid_cur", cur_freq, 0);
    check("rmid_done", done, 0);
    tick();
    reset = 1'b0;
    tick();
    check("rmid_idle", busy, 0);
    check("rmid_nodone", done_seen, d0);
    start_tone(16'd1000, 16'd1);
    check("rmid_restart_busy", busy, 1);
    to_play(16'd1000);
    repeat (1000) tick();
    check("rmid_done_pulse", done, 1);
    tick();
    check("rmid_done_once", done_seen, d0 + 1);
    check("rmid_end_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
